seq_match_window_counter: RTL and testbench

//  Downstream consumer of the serial sequence detectors (e.g. 11011 overlapping Mealy).

---
 rtl/seq_match_window_counter.sv | 181 ++++++++++++++++++
 tb/tb_seq_match_window_counter.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_match_window_counter.sv
// seq_match_window_counter
//   Counts detector match pulses over fixed windows of WIN_LEN input-bit
//   strobes and publishes each window's count through a valid/ready port.
//   Optional feature macro: SEQ_MATCH_IRQ_EN adds the IRQ_THRESH parameter
//   and the irq output (one-cycle pulse when a window reaches the threshold).
module seq_match_window_counter #(
    parameter int CNT_W      = 8,
    parameter int WIN_LEN    = 64
`ifdef SEQ_MATCH_IRQ_EN
    ,
    parameter int IRQ_THRESH = 4
`endif
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             bit_vld,
    input  logic             match,
    input  logic             rpt_ready,
    output logic             rpt_valid,
    output logic [CNT_W-1:0] rpt_count,
    output logic             rpt_sat,
    output logic             rpt_ovr,
    output logic             busy
`ifdef SEQ_MATCH_IRQ_EN
    ,
    output logic             irq
`endif
);

    localparam int             BW       = $clog2(WIN_LEN + 1);
    localparam logic [BW-1:0]  LAST_BIT = BW'(WIN_LEN - 1);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        COUNT = 1'b1
    } state_t;

    state_t           state_r;
    state_t           state_nxt_s;
    logic             busy_s;

    logic [BW-1:0]    bit_cnt_r;
    logic [CNT_W-1:0] match_cnt_r;
    logic             sat_r;

    logic             rpt_valid_r;
    logic [CNT_W-1:0] rpt_count_r;
    logic             rpt_sat_r;
    logic             rpt_ovr_r;

    logic             counting_s;
    logic             close_s;
    logic             match_inc_s;
    logic [CNT_W-1:0] final_cnt_s;
    logic             final_sat_s;
    logic             accept_s;
    logic             load_s;
    logic             drop_s;

    // Window datapath decode: a closing strobe reports the count including
    // any match arriving in the same cycle; a dropped result needs a full,
    // un-accepted report register.
    always_comb begin
        counting_s  = (state_r == COUNT) && en;
        close_s     = counting_s && bit_vld && (bit_cnt_r == LAST_BIT);
        match_inc_s = counting_s && match && (match_cnt_r != CNT_MAX);
        if (match_inc_s) begin
            final_cnt_s = match_cnt_r + CNT_W'(1);
        end else begin
            final_cnt_s = match_cnt_r;
        end
        final_sat_s = sat_r || (final_cnt_s == CNT_MAX);
        accept_s    = rpt_valid_r && rpt_ready;
        load_s      = close_s && (!rpt_valid_r || rpt_ready);
        drop_s      = close_s && rpt_valid_r && !rpt_ready;
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // FSM next-state: en alone moves between IDLE and COUNT.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE:    state_nxt_s = en ? COUNT : IDLE;
            COUNT:   state_nxt_s = en ? COUNT : IDLE;
            default: state_nxt_s = IDLE;
        endcase
    end

    // FSM outputs, decoded straight from the state register.
    always_comb begin
        busy_s = 1'b0;
        case (state_r)
            IDLE:    busy_s = 1'b0;
            COUNT:   busy_s = 1'b1;
            default: busy_s = 1'b0;
        endcase
    end

    // Window counters: cleared outside counting and on window close so the
    // next strobe is counted with no dead cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bit_cnt_r   <= {BW{1'b0}};
            match_cnt_r <= {CNT_W{1'b0}};
            sat_r       <= 1'b0;
        end else if (!counting_s || close_s) begin
            bit_cnt_r   <= {BW{1'b0}};
            match_cnt_r <= {CNT_W{1'b0}};
            sat_r       <= 1'b0;
        end else begin
            if (bit_vld) begin
                bit_cnt_r <= bit_cnt_r + BW'(1);
            end else begin
                bit_cnt_r <= bit_cnt_r;
            end
            match_cnt_r <= final_cnt_s;
            sat_r       <= final_sat_s;
        end
    end

    // Report register with valid/ready handshake and sticky overrun flag.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rpt_valid_r <= 1'b0;
            rpt_count_r <= {CNT_W{1'b0}};
            rpt_sat_r   <= 1'b0;
            rpt_ovr_r   <= 1'b0;
        end else begin
            if (load_s) begin
                rpt_valid_r <= 1'b1;
                rpt_count_r <= final_cnt_s;
                rpt_sat_r   <= final_sat_s;
            end else if (accept_s) begin
                rpt_valid_r <= 1'b0;
            end else begin
                rpt_valid_r <= rpt_valid_r;
            end
            if (drop_s) begin
                rpt_ovr_r <= 1'b1;
            end else if (accept_s) begin
                rpt_ovr_r <= 1'b0;
            end else begin
                rpt_ovr_r <= rpt_ovr_r;
            end
        end
    end

`ifdef SEQ_MATCH_IRQ_EN
    localparam logic [CNT_W-1:0] IRQ_LVL = CNT_W'(IRQ_THRESH);
    logic irq_r;

    // Threshold pulse: the count only moves upward within a window, so the
    // step onto IRQ_LVL happens at most once per window.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            irq_r <= 1'b0;
        end else begin
            irq_r <= match_inc_s && (final_cnt_s == IRQ_LVL);
        end
    end

    assign irq = irq_r;
`endif

    assign rpt_valid = rpt_valid_r;
    assign rpt_count = rpt_count_r;
    assign rpt_sat   = rpt_sat_r;
    assign rpt_ovr   = rpt_ovr_r;
    assign busy      = busy_s;

endmodule

// File: tb/tb_seq_match_window_counter.sv
// Testbench for seq_match_window_counter: scoreboard of expected window
// reports, pushed when a window is driven and popped when the report is
// consumed.
module tb_seq_match_window_counter;

    localparam int CNT_W   = 4;
    localparam int WIN_LEN = 64;
    localparam int CMAX    = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             en = 1'b0;
    logic             bit_vld = 1'b0;
    logic             match = 1'b0;
    logic             rpt_ready = 1'b0;
    logic             rpt_valid;
    logic [CNT_W-1:0] rpt_count;
    logic             rpt_sat;
    logic             rpt_ovr;
    logic             busy;
`ifdef SEQ_MATCH_IRQ_EN
    logic             irq;
`endif

    typedef struct packed {
        logic [CNT_W-1:0] cnt;
        logic             sat;
    } rpt_t;

    rpt_t sb_q[$];
    bit   m_valid = 1'b0;
    bit   m_ovr   = 1'b0;
    int   n_cmp   = 0;
    int   n_bad   = 0;

    seq_match_window_counter #(
        .CNT_W     (CNT_W),
        .WIN_LEN   (WIN_LEN)
`ifdef SEQ_MATCH_IRQ_EN
        ,
        .IRQ_THRESH(4)
`endif
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .bit_vld  (bit_vld),
        .match    (match),
        .rpt_ready(rpt_ready),
        .rpt_valid(rpt_valid),
        .rpt_count(rpt_count),
        .rpt_sat  (rpt_sat),
        .rpt_ovr  (rpt_ovr),
        .busy     (busy)
`ifdef SEQ_MATCH_IRQ_EN
        ,
        .irq      (irq)
`endif
    );

    always #5 clk = ~clk;

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    // Drive one full window; matches occupy the last nmatch strobes so the
    // closing strobe carries a match whenever nmatch > 0.
    task automatic drive_window(input int nbits, input int nmatch, input bit rdy_close);
        rpt_t exp;
        rpt_t cur;
        bit   acc;
        for (int i = 0; i < nbits; i++) begin
            bit_vld   = 1'b1;
            match     = (i >= nbits - nmatch);
            rpt_ready = 1'b0;
            if (i == nbits - 1) begin
                n_cmp++;
                if (rpt_valid !== m_valid) begin
                    n_bad++;
                    $display("FAIL pre_close_valid: got %0b expected %0b", rpt_valid, m_valid);
                end
                if (rdy_close && m_valid) begin
                    rpt_ready = 1'b1;
                    cur = sb_q.pop_front();
                    n_cmp++;
                    if (rpt_count !== cur.cnt || rpt_sat !== cur.sat) begin
                        n_bad++;
                        $display("FAIL close_accept_rpt: got cnt=%0d sat=%0b expected cnt=%0d sat=%0b",
                                 rpt_count, rpt_sat, cur.cnt, cur.sat);
                    end
                end
            end
            step();
        end
        bit_vld   = 1'b0;
        match     = 1'b0;
        rpt_ready = 1'b0;
        exp.cnt = (nmatch > CMAX) ? CNT_W'(CMAX) : CNT_W'(nmatch);
        exp.sat = (nmatch >= CMAX);
        acc = m_valid && rdy_close;
        if (acc) m_ovr = 1'b0;
        if (!m_valid || acc) begin
            sb_q.push_back(exp);
            m_valid = 1'b1;
        end else begin
            m_ovr = 1'b1;
        end
        n_cmp++;
        if (rpt_valid !== m_valid || rpt_ovr !== m_ovr) begin
            n_bad++;
            $display("FAIL post_close_flags: got valid=%0b ovr=%0b expected valid=%0b ovr=%0b",
                     rpt_valid, rpt_ovr, m_valid, m_ovr);
        end
        if (sb_q.size() > 0) begin
            n_cmp++;
            if (rpt_count !== sb_q[0].cnt || rpt_sat !== sb_q[0].sat) begin
                n_bad++;
                $display("FAIL held_rpt: got cnt=%0d sat=%0b expected cnt=%0d sat=%0b",
                         rpt_count, rpt_sat, sb_q[0].cnt, sb_q[0].sat);
            end
        end
    endtask

    // Consume the pending report and check the port empties.
    task automatic accept_report;
        rpt_t exp;
        if (sb_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL accept_empty_scoreboard: got 0 entries expected 1");
        end else begin
            exp = sb_q.pop_front();
            n_cmp++;
            if (rpt_valid !== 1'b1 || rpt_count !== exp.cnt || rpt_sat !== exp.sat) begin
                n_bad++;
                $display("FAIL accept_rpt: got valid=%0b cnt=%0d sat=%0b expected valid=1 cnt=%0d sat=%0b",
                         rpt_valid, rpt_count, rpt_sat, exp.cnt, exp.sat);
            end
        end
        rpt_ready = 1'b1;
        step();
        rpt_ready = 1'b0;
        m_valid = 1'b0;
        m_ovr   = 1'b0;
        n_cmp++;
        if (rpt_valid !== 1'b0 || rpt_ovr !== 1'b0) begin
            n_bad++;
            $display("FAIL after_accept: got valid=%0b ovr=%0b expected valid=0 ovr=0", rpt_valid, rpt_ovr);
        end
    endtask

    task automatic test_reset;
        rst = 1'b0;
        en  = 1'b0;
        step();
        n_cmp++;
        if ({rpt_valid, rpt_count, rpt_sat, rpt_ovr, busy} !== {(CNT_W + 4){1'b0}}) begin
            n_bad++;
            $display("FAIL reset_outputs: got valid=%0b cnt=%0d sat=%0b ovr=%0b busy=%0b expected all 0",
                     rpt_valid, rpt_count, rpt_sat, rpt_ovr, busy);
        end
        rst = 1'b1;
        step();
        en = 1'b1;
        step();
        n_cmp++;
        if (busy !== 1'b1) begin
            n_bad++;
            $display("FAIL busy_after_en: got %0b expected 1", busy);
        end
    endtask

    task automatic test_window;
        drive_window(WIN_LEN, 3, 1'b0);
    endtask

    task automatic test_drop;
        drive_window(WIN_LEN, 2, 1'b0);
        accept_report();
    endtask

    task automatic test_close_accept;
        drive_window(WIN_LEN, 1, 1'b0);
        drive_window(WIN_LEN, 0, 1'b0);
        drive_window(WIN_LEN, 5, 1'b1);
        accept_report();
    endtask

    task automatic test_back_to_back;
        drive_window(WIN_LEN, 20, 1'b0);
        drive_window(WIN_LEN, 2, 1'b1);
        accept_report();
    endtask

    task automatic test_disable;
        for (int i = 0; i < 30; i++) begin
            bit_vld = 1'b1;
            match   = (i < 2);
            step();
        end
        en      = 1'b0;
        bit_vld = 1'b1;
        match   = 1'b1;
        step();
        bit_vld = 1'b0;
        match   = 1'b0;
        n_cmp++;
        if (busy !== 1'b0 || rpt_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL disable_discard: got busy=%0b valid=%0b expected busy=0 valid=0", busy, rpt_valid);
        end
        step();
        en = 1'b1;
        step();
        drive_window(WIN_LEN, 1, 1'b0);
        accept_report();
    endtask

`ifdef SEQ_MATCH_IRQ_EN
    task automatic test_irq;
        rpt_t exp;
        for (int i = 0; i < WIN_LEN; i++) begin
            bit_vld = 1'b1;
            match   = (i >= 2 && i < 8);
            step();
            n_cmp++;
            if (irq !== (i == 5)) begin
                n_bad++;
                $display("FAIL irq_pulse[%0d]: got %0b expected %0b", i, irq, (i == 5));
            end
        end
        bit_vld = 1'b0;
        match   = 1'b0;
        exp.cnt = CNT_W'(6);
        exp.sat = 1'b0;
        sb_q.push_back(exp);
        m_valid = 1'b1;
        n_cmp++;
        if (rpt_valid !== 1'b1 || rpt_count !== exp.cnt) begin
            n_bad++;
            $display("FAIL irq_window_rpt: got valid=%0b cnt=%0d expected valid=1 cnt=6", rpt_valid, rpt_count);
        end
    endtask
`endif

    task automatic test_reset_mid;
        if (!m_valid) drive_window(WIN_LEN, 2, 1'b0);
        for (int i = 0; i < 10; i++) begin
            bit_vld = 1'b1;
            match   = 1'b1;
            step();
        end
        rst = 1'b0;
        #2;
        n_cmp++;
        if ({rpt_valid, rpt_count, rpt_sat, rpt_ovr, busy} !== {(CNT_W + 4){1'b0}}) begin
            n_bad++;
            $display("FAIL reset_mid_outputs: got valid=%0b cnt=%0d sat=%0b ovr=%0b busy=%0b expected all 0",
                     rpt_valid, rpt_count, rpt_sat, rpt_ovr, busy);
        end
`ifdef SEQ_MATCH_IRQ_EN
        n_cmp++;
        if (irq !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_mid_irq: got %0b expected 0", irq);
        end
`endif
        bit_vld = 1'b0;
        match   = 1'b0;
        sb_q.delete();
        m_valid = 1'b0;
        m_ovr   = 1'b0;
        step();
        rst = 1'b1;
        step();
        step();
        drive_window(WIN_LEN, 4, 1'b0);
        accept_report();
    endtask

    initial begin
        test_reset();
        test_window();
        test_drop();
        test_close_accept();
        test_back_to_back();
        test_disable();
`ifdef SEQ_MATCH_IRQ_EN
        test_irq();
`endif
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
